ss_src_seq: RTL and testbench

//  Source-side transfer sequencer for one stream-DMA channel. Accepts a command (start address + 64-bit word count),

---
 rtl/ss_src_seq_pkg.sv | 14 +
 rtl/ss_src_seq.sv | 111 +++++++++++
 tb/tb_ss_src_seq.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ss_src_seq_pkg.sv
// Shared types and constants for the stream-DMA source sequencer.
package ss_src_seq_pkg;

   typedef enum logic [1:0] {
      SS_SEQ_IDLE  = 2'd0,
      SS_SEQ_WAIT  = 2'd1,
      SS_SEQ_BURST = 2'd2,
      SS_SEQ_DONE  = 2'd3
   } seq_state_t;

   localparam int unsigned SS_BEAT_BYTES = 8;
   localparam int unsigned BURST_CNT_W   = 8;

endpackage

// File: rtl/ss_src_seq.sv
// Source-side transfer sequencer: turns a (start address, word count) command into read bursts feeding the
// channel source FIFO. Optional macro SS_SEQ_STATS_EN adds the stall_cnt flow-control statistics port.
module ss_src_seq
   import ss_src_seq_pkg::*;
#(
   parameter int unsigned BURST = 8,
   parameter int unsigned CNT_W = 24,
   parameter int unsigned AW    = 32
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             m_reset0,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [AW-1:0]    cmd_addr,
   input  logic [CNT_W-1:0] cmd_cnt,
   input  logic             ss_start0,
   input  logic             ss_stop0,
   output logic             bus_req,
   output logic [AW-1:0]    bus_adr,
   input  logic             bus_ack,
   output logic             ss_xfer0,
   output logic             ss_last0,
   output logic             busy,
   output logic             done
`ifdef SS_SEQ_STATS_EN
   ,
   output logic [15:0]      stall_cnt
`endif
);

   localparam int unsigned BC_W = BURST_CNT_W;

   seq_state_t       state;
   seq_state_t       next_state;
   logic [CNT_W-1:0] remaining;
   logic [BC_W-1:0]  burst_cnt;
   logic [BC_W-1:0]  burst_load;
   logic             accept;
   logic             wait_go;
   logic             last_rem;

   assign accept     = cmd_valid & cmd_ready;
   assign wait_go    = (state == SS_SEQ_WAIT) & ss_start0 & ~ss_stop0;
   assign last_rem   = (remaining == CNT_W'(1));
   assign burst_load = (remaining < CNT_W'(BURST)) ? BC_W'(remaining) : BC_W'(BURST);

   // State register
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) state <= SS_SEQ_IDLE;
      else          state <= next_state;
   end

   // Next-state logic; channel abort overrides every transition
   always_comb begin
      next_state = state;
      unique case (state)
         SS_SEQ_IDLE:  if (accept) next_state = (cmd_cnt == '0) ? SS_SEQ_DONE : SS_SEQ_WAIT;
         SS_SEQ_WAIT:  if (wait_go) next_state = SS_SEQ_BURST;
         SS_SEQ_BURST: begin
            if (ss_xfer0) begin
               if (last_rem)                       next_state = SS_SEQ_DONE;
               else if (burst_cnt == BC_W'(1))     next_state = SS_SEQ_WAIT;
            end
         end
         SS_SEQ_DONE:  next_state = SS_SEQ_IDLE;
         default:      next_state = SS_SEQ_IDLE;
      endcase
      if (m_reset0) next_state = SS_SEQ_IDLE;
   end

   // Outputs; the FIFO strobe is same-cycle with the acknowledged beat
   always_comb begin
      cmd_ready = (state == SS_SEQ_IDLE) & ~m_reset0;
      busy      = (state != SS_SEQ_IDLE);
      done      = (state == SS_SEQ_DONE) & ~m_reset0;
      bus_req   = (state == SS_SEQ_BURST) & ~ss_stop0;
      ss_xfer0  = bus_req & bus_ack & ~m_reset0;
      ss_last0  = ss_xfer0 & last_rem;
   end

   // Word/burst counters and beat address
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || m_reset0) begin
         remaining <= '0;
         burst_cnt <= '0;
         bus_adr   <= '0;
      end else if (accept) begin
         remaining <= cmd_cnt;
         bus_adr   <= cmd_addr & ~AW'(SS_BEAT_BYTES - 1);
      end else if (wait_go) begin
         burst_cnt <= burst_load;
      end else if (ss_xfer0) begin
         remaining <= remaining - CNT_W'(1);
         burst_cnt <= burst_cnt - BC_W'(1);
         bus_adr   <= bus_adr + AW'(SS_BEAT_BYTES);
      end
   end

`ifdef SS_SEQ_STATS_EN
   // A stall is a cycle held back by FIFO flow control, either before or inside a burst
   logic stall;
   assign stall = (state == SS_SEQ_WAIT && !wait_go) || (state == SS_SEQ_BURST && !bus_req);

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || m_reset0 || accept) stall_cnt <= '0;
      else if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_ss_src_seq.sv
// Directed self-checking bench for ss_src_seq; stall_cnt checks are active when SS_SEQ_STATS_EN is defined.
module tb_ss_src_seq;

   logic        clk = 1'b0;
   logic        wb_rst_i;
   logic        m_reset0;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_addr;
   logic [23:0] cmd_cnt;
   logic        ss_start0;
   logic        ss_stop0;
   logic        bus_req;
   logic [31:0] bus_adr;
   logic        bus_ack;
   logic        ss_xfer0;
   logic        ss_last0;
   logic        busy;
   logic        done;
`ifdef SS_SEQ_STATS_EN
   logic [15:0] stall_cnt;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ss_src_seq #(.BURST(8), .CNT_W(24), .AW(32)) dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (wb_rst_i),
      .m_reset0  (m_reset0),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_addr  (cmd_addr),
      .cmd_cnt   (cmd_cnt),
      .ss_start0 (ss_start0),
      .ss_stop0  (ss_stop0),
      .bus_req   (bus_req),
      .bus_adr   (bus_adr),
      .bus_ack   (bus_ack),
      .ss_xfer0  (ss_xfer0),
      .ss_last0  (ss_last0),
      .busy      (busy),
      .done      (done)
`ifdef SS_SEQ_STATS_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   // Presents a command for one cycle and confirms it was accepted; returns at the start of cycle 1.
   task automatic issue_cmd(input logic [31:0] addr, input logic [23:0] cnt, input logic start);
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_addr = addr; cmd_cnt = cnt; ss_start0 = start; ss_stop0 = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (cmd_ready !== 1'b1) begin
         n_fail++; $display("FAIL accept_%0d: cmd_ready=%b want 1", cnt, cmd_ready);
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      wb_rst_i = 1'b1; m_reset0 = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_cnt = '0;
      ss_start0 = 1'b0; ss_stop0 = 1'b0; bus_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1 wb_rst_i = 1'b0;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0)      begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
      n_cmp++; if (bus_req !== 1'b0)   begin n_fail++; $display("FAIL rst_req: got %b want 0", bus_req); end
      n_cmp++; if (ss_xfer0 !== 1'b0)  begin n_fail++; $display("FAIL rst_xfer: got %b want 0", ss_xfer0); end
      n_cmp++; if (bus_adr !== 32'h0)  begin n_fail++; $display("FAIL rst_adr: got %h want 0", bus_adr); end
      n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
`ifdef SS_SEQ_STATS_EN
      n_cmp++; if (stall_cnt !== 16'h0) begin n_fail++; $display("FAIL rst_stall: got %0d want 0", stall_cnt); end
`endif
   endtask

   task automatic test_bursts_20();
      int nx = 0, nlast = 0, last_at = -1, ndone = 0, done_at = -1, nbusy = 0, run = 0;
      int runs[$];
      logic [31:0] exp_adr = 32'h0000_1000;
      bus_ack = 1'b1;
      issue_cmd(32'h0000_1004, 24'd20, 1'b1);
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (busy) nbusy++;
         if (ss_xfer0) begin
            n_cmp++;
            if (bus_adr !== exp_adr) begin n_fail++; $display("FAIL b20_adr: got %h want %h", bus_adr, exp_adr); end
            exp_adr += 32'd8; nx++; run++;
            if (ss_last0) begin nlast++; last_at = c; end
         end else if (run != 0) begin
            runs.push_back(run); run = 0;
         end
         if (done) begin ndone++; done_at = c; end
         @(posedge clk); #1;
      end
      n_cmp++; if (nx != 20)      begin n_fail++; $display("FAIL b20_xfers: got %0d want 20", nx); end
      n_cmp++; if (nlast != 1)    begin n_fail++; $display("FAIL b20_nlast: got %0d want 1", nlast); end
      n_cmp++; if (last_at != 23) begin n_fail++; $display("FAIL b20_last_cycle: got %0d want 23", last_at); end
      n_cmp++; if (ndone != 1)    begin n_fail++; $display("FAIL b20_ndone: got %0d want 1", ndone); end
      n_cmp++; if (done_at != 24) begin n_fail++; $display("FAIL b20_done_cycle: got %0d want 24", done_at); end
      n_cmp++; if (nbusy != 24)   begin n_fail++; $display("FAIL b20_busy_cycles: got %0d want 24", nbusy); end
      n_cmp++;
      if (runs.size() != 3) begin
         n_fail++; $display("FAIL b20_nbursts: got %0d want 3", runs.size());
      end else if (runs[0] != 8 || runs[1] != 8 || runs[2] != 4) begin
         n_fail++; $display("FAIL b20_burst_lens: got %0d,%0d,%0d want 8,8,4", runs[0], runs[1], runs[2]);
      end
   endtask

   task automatic test_zero_cnt();
      int nbusy = 0, ndone = 0, done_at = -1, nreq = 0;
      bus_ack = 1'b1;
      issue_cmd(32'h0000_0100, 24'd0, 1'b1);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         if (busy) nbusy++;
         if (bus_req) nreq++;
         if (done) begin ndone++; done_at = c; end
         if (c == 2) begin
            n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL z_ready_after: got %b want 1", cmd_ready); end
         end
         @(posedge clk); #1;
      end
      n_cmp++; if (nreq != 0)    begin n_fail++; $display("FAIL z_req: got %0d want 0", nreq); end
      n_cmp++; if (nbusy != 1)   begin n_fail++; $display("FAIL z_busy: got %0d want 1", nbusy); end
      n_cmp++; if (ndone != 1)   begin n_fail++; $display("FAIL z_ndone: got %0d want 1", ndone); end
      n_cmp++; if (done_at != 1) begin n_fail++; $display("FAIL z_done_cycle: got %0d want 1", done_at); end
   endtask

   task automatic test_stop_pause();
      int nx = 0, x_in_stop = 0, req_low_stop = 0, last_at = -1, done_at = -1;
      logic [31:0] exp_adr = 32'h0000_0200;
      bus_ack = 1'b1;
      issue_cmd(32'h0000_0200, 24'd5, 1'b1);
      for (int c = 1; c <= 14; c++) begin
         ss_stop0 = (c >= 4 && c <= 7);
         @(negedge clk);
         if (ss_xfer0) begin
            n_cmp++;
            if (bus_adr !== exp_adr) begin n_fail++; $display("FAIL stop_adr: got %h want %h", bus_adr, exp_adr); end
            exp_adr += 32'd8; nx++;
            if (ss_last0) last_at = c;
         end
         if (c >= 4 && c <= 7) begin
            if (ss_xfer0) x_in_stop++;
            if (!bus_req) req_low_stop++;
         end
         if (done) begin
            done_at = c;
`ifdef SS_SEQ_STATS_EN
            n_cmp++; if (stall_cnt !== 16'd4) begin n_fail++; $display("FAIL stop_stall_cnt: got %0d want 4", stall_cnt); end
`endif
         end
         @(posedge clk); #1;
      end
      n_cmp++; if (nx != 5)           begin n_fail++; $display("FAIL stop_xfers: got %0d want 5", nx); end
      n_cmp++; if (x_in_stop != 0)    begin n_fail++; $display("FAIL stop_xfer_paused: got %0d want 0", x_in_stop); end
      n_cmp++; if (req_low_stop != 4) begin n_fail++; $display("FAIL stop_req_low: got %0d want 4", req_low_stop); end
      n_cmp++; if (last_at != 10)     begin n_fail++; $display("FAIL stop_last_cycle: got %0d want 10", last_at); end
      n_cmp++; if (done_at != 11)     begin n_fail++; $display("FAIL stop_done_cycle: got %0d want 11", done_at); end
   endtask

   task automatic test_addr_wrap();
      int nx = 0, last_at = -1, done_at = -1;
      logic [31:0] exp_q [3];
      exp_q[0] = 32'hFFFF_FFF8; exp_q[1] = 32'h0000_0000; exp_q[2] = 32'h0000_0008;
      bus_ack = 1'b0;
      issue_cmd(32'hFFFF_FFFD, 24'd3, 1'b1);
      for (int c = 1; c <= 10; c++) begin
         bus_ack = (c % 2 == 0);
         @(negedge clk);
         if (ss_xfer0) begin
            if (nx < 3) begin
               n_cmp++;
               if (bus_adr !== exp_q[nx]) begin n_fail++; $display("FAIL wrap_adr%0d: got %h want %h", nx, bus_adr, exp_q[nx]); end
            end
            nx++;
            if (ss_last0) last_at = c;
         end
         if (done) done_at = c;
         @(posedge clk); #1;
      end
      n_cmp++; if (nx != 3)      begin n_fail++; $display("FAIL wrap_xfers: got %0d want 3", nx); end
      n_cmp++; if (last_at != 6) begin n_fail++; $display("FAIL wrap_last_cycle: got %0d want 6", last_at); end
      n_cmp++; if (done_at != 7) begin n_fail++; $display("FAIL wrap_done_cycle: got %0d want 7", done_at); end
   endtask

   task automatic test_abort();
      int nx = 0, ndone = 0;
      bus_ack = 1'b1;
      issue_cmd(32'h0000_0040, 24'd10, 1'b1);
      for (int c = 1; c <= 10; c++) begin
         m_reset0 = (c == 5);
         @(negedge clk);
         if (ss_xfer0) nx++;
         if (done) ndone++;
         if (c == 5) begin
            n_cmp++; if (ss_xfer0 !== 1'b0)  begin n_fail++; $display("FAIL abort_xfer: got %b want 0", ss_xfer0); end
            n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL abort_ready_during: got %b want 0", cmd_ready); end
         end
         if (c == 6) begin
            n_cmp++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
            n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b want 1", cmd_ready); end
            n_cmp++; if (bus_req !== 1'b0)   begin n_fail++; $display("FAIL abort_req: got %b want 0", bus_req); end
         end
         @(posedge clk); #1;
      end
      m_reset0 = 1'b0;
      n_cmp++; if (nx != 3)    begin n_fail++; $display("FAIL abort_xfers: got %0d want 3", nx); end
      n_cmp++; if (ndone != 0) begin n_fail++; $display("FAIL abort_done: got %0d want 0", ndone); end
   endtask

   task automatic test_start_hold();
      int nreq_hold = 0, nbusy_hold = 0, first_req = -1, nx = 0, done_at = -1;
      bus_ack = 1'b1;
      issue_cmd(32'h0000_0800, 24'd2, 1'b0);
      for (int c = 1; c <= 16; c++) begin
         ss_start0 = (c >= 11);
         @(negedge clk);
         if (c <= 10) begin
            if (bus_req) nreq_hold++;
            if (busy) nbusy_hold++;
         end
         if (bus_req && first_req < 0) first_req = c;
         if (ss_xfer0) nx++;
         if (done) begin
            done_at = c;
`ifdef SS_SEQ_STATS_EN
            n_cmp++; if (stall_cnt !== 16'd10) begin n_fail++; $display("FAIL hold_stall_cnt: got %0d want 10", stall_cnt); end
`endif
         end
         @(posedge clk); #1;
      end
      n_cmp++; if (nreq_hold != 0)   begin n_fail++; $display("FAIL hold_req: got %0d want 0", nreq_hold); end
      n_cmp++; if (nbusy_hold != 10) begin n_fail++; $display("FAIL hold_busy: got %0d want 10", nbusy_hold); end
      n_cmp++; if (first_req != 12)  begin n_fail++; $display("FAIL hold_first_req: got %0d want 12", first_req); end
      n_cmp++; if (nx != 2)          begin n_fail++; $display("FAIL hold_xfers: got %0d want 2", nx); end
      n_cmp++; if (done_at != 14)    begin n_fail++; $display("FAIL hold_done_cycle: got %0d want 14", done_at); end
   endtask

   task automatic test_back_to_back();
      int accept_at = -1, ndone = 0, done_first = -1, done_last = -1;
      bus_ack = 1'b1;
      issue_cmd(32'h0000_0300, 24'd1, 1'b1);
      cmd_valid = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (cmd_valid && cmd_ready && accept_at < 0) accept_at = c;
         if (done) begin
            ndone++; done_last = c;
            if (done_first < 0) done_first = c;
         end
         @(posedge clk); #1;
         if (accept_at >= 0) cmd_valid = 1'b0;
      end
      n_cmp++; if (accept_at != 4)  begin n_fail++; $display("FAIL b2b_accept_cycle: got %0d want 4", accept_at); end
      n_cmp++; if (ndone != 2)      begin n_fail++; $display("FAIL b2b_ndone: got %0d want 2", ndone); end
      n_cmp++; if (done_first != 3) begin n_fail++; $display("FAIL b2b_done1: got %0d want 3", done_first); end
      n_cmp++; if (done_last != 7)  begin n_fail++; $display("FAIL b2b_done2: got %0d want 7", done_last); end
   endtask

   initial begin
      test_reset();
      test_bursts_20();
      test_zero_cnt();
      test_stop_pause();
      test_addr_wrap();
      test_abort();
      test_start_hold();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
